axi_ar_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one AXI AR channel between NumReq requesters.

---
 rtl/axi_ar_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_axi_ar_rr_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_ar_rr_arbiter.sv
// Round-robin arbiter sharing one AXI AR channel between NumReq requesters, with a one-entry output register.
// Define AR_ARB_STARVE_EN to add per-requester wait counters that override round-robin after MaxWait cycles.
module axi_ar_rr_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned MaxWait   = 15,
  localparam int unsigned ArW      = IdWidth + AddrWidth + 29 + UserWidth,
  localparam int unsigned IdxW     = (NumReq > 2) ? $clog2(NumReq) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      slv_valid_i,
  output logic [NumReq-1:0]      slv_ready_o,
  input  logic [NumReq*ArW-1:0]  slv_data_i,
  output logic                   mst_valid_o,
  input  logic                   mst_ready_i,
  output logic [IdxW+ArW-1:0]    mst_data_o,
  output logic                   busy_o
);

  // Handshakes: a beat transfers on a side only in a cycle where valid and
  // ready are both high at the rising edge; valid never waits on ready, and the
  // output beat is held stable while mst_valid_o=1 and mst_ready_i=0.

  logic                 mst_valid_q;
  logic [IdxW+ArW-1:0]  mst_data_q;
  logic [IdxW-1:0]      rr_ptr_q;

  logic                 load_en;
  logic                 any_valid;
  logic                 slv_hs;
  logic                 rr_found;
  logic [IdxW-1:0]      rr_winner;
  logic [IdxW-1:0]      winner;
  logic [ArW-1:0]       win_beat;

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NumReq) s = s - NumReq;
    return IdxW'(s);
  endfunction

  assign load_en   = ~mst_valid_q | mst_ready_i;
  assign any_valid = |slv_valid_i;
  assign slv_hs    = rst_ni & load_en & any_valid;

  // Scan upward from the pointer, wrapping at NumReq-1.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!rr_found && slv_valid_i[wrap_idx(rr_ptr_q, k)]) begin
        rr_found  = 1'b1;
        rr_winner = wrap_idx(rr_ptr_q, k);
      end
    end
  end

`ifdef AR_ARB_STARVE_EN
  localparam int unsigned CntW = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;

  logic [CntW-1:0] wait_cnt_q [NumReq];
  logic            st_found;
  logic [IdxW-1:0] st_winner;

  // Lowest-index starved requester beats the round-robin choice.
  always_comb begin
    st_found  = 1'b0;
    st_winner = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!st_found && slv_valid_i[i] && (wait_cnt_q[i] >= CntW'(MaxWait))) begin
        st_found  = 1'b1;
        st_winner = IdxW'(i);
      end
    end
  end

  assign winner = st_found ? st_winner : rr_winner;

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!rst_ni) begin
        wait_cnt_q[i] <= '0;
      end else if (!slv_valid_i[i] || (slv_hs && (winner == IdxW'(i)))) begin
        wait_cnt_q[i] <= '0;
      end else if (wait_cnt_q[i] != CntW'(MaxWait)) begin
        wait_cnt_q[i] <= wait_cnt_q[i] + CntW'(1);
      end
    end
  end
`else
  logic unused_max_wait;

  assign unused_max_wait = ^32'(MaxWait);
  assign winner          = rr_winner;
`endif

  always_comb begin
    win_beat = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (winner == IdxW'(i)) win_beat = slv_data_i[i*ArW +: ArW];
    end
  end

  always_comb begin
    slv_ready_o = '0;
    if (slv_hs) slv_ready_o[winner] = 1'b1;
  end

  // Drain and refill in the same cycle keeps full throughput.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mst_valid_q <= 1'b0;
      mst_data_q  <= '0;
    end else if (load_en) begin
      mst_valid_q <= any_valid;
      if (any_valid) mst_data_q <= {winner, win_beat};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (slv_hs) begin
      rr_ptr_q <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + IdxW'(1);
    end
  end

  assign mst_valid_o = mst_valid_q;
  assign mst_data_o  = mst_data_q;
  assign busy_o      = mst_valid_q;

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
// Bench for axi_ar_rr_arbiter: vector table, hand sequences and random traffic against a scoreboard model.
// Build with AR_ARB_STARVE_EN defined to exercise the starvation override (MaxWait=2).
module tb_axi_ar_rr_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int ADDR_W   = 64;
  localparam int ID_W     = 4;
  localparam int USER_W   = 1;
  localparam int MAX_WAIT = 2;
  localparam int ARW      = ID_W + ADDR_W + 29 + USER_W;
  localparam int IDXW     = 2;
  localparam int W        = IDXW + ARW;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic [NUM_REQ-1:0]       slv_valid_i;
  logic [NUM_REQ-1:0]       slv_ready_o;
  logic [NUM_REQ*ARW-1:0]   slv_data_i;
  logic                     mst_valid_o;
  logic                     mst_ready_i;
  logic [W-1:0]             mst_data_o;
  logic                     busy_o;

  always #5 clk_i = ~clk_i;

  axi_ar_rr_arbiter #(
    .NumReq    (NUM_REQ),
    .AddrWidth (ADDR_W),
    .IdWidth   (ID_W),
    .UserWidth (USER_W),
    .MaxWait   (MAX_WAIT)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .slv_valid_i (slv_valid_i),
    .slv_ready_o (slv_ready_o),
    .slv_data_i  (slv_data_i),
    .mst_valid_o (mst_valid_o),
    .mst_ready_i (mst_ready_i),
    .mst_data_o  (mst_data_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic               rn;
    logic [NUM_REQ-1:0] v;
    logic               r;
    logic [NUM_REQ-1:0] rdy;
  } vec_t;

  vec_t         tab[$];
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  int   m_ptr;
  logic m_valid;
  logic m_zero;
  int   m_cnt[NUM_REQ];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_zero  = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic rn, input logic [NUM_REQ-1:0] v, input logic r,
                       input logic chk_tab, input logic [NUM_REQ-1:0] tab_rdy);
    logic               exp_load;
    int                 win;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [ARW-1:0]     beat;
    rst_ni      = rn;
    slv_valid_i = v;
    mst_ready_i = r;
    for (int b = 0; b < NUM_REQ*ARW; b++) slv_data_i[b] = 1'($urandom_range(0, 1));
    #2;
    exp_load = !m_valid || r;
    win = -1;
`ifdef AR_ARB_STARVE_EN
    for (int i = 0; i < NUM_REQ; i++)
      if (win < 0 && v[i] && m_cnt[i] >= MAX_WAIT) win = i;
`endif
    for (int k = 0; k < NUM_REQ; k++)
      if (win < 0 && v[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
    exp_rdy = '0;
    if (rn && exp_load && win >= 0) exp_rdy[win] = 1'b1;

    check("slv_ready", W'(slv_ready_o), W'(exp_rdy));
    if (chk_tab) check("tab_ready", W'(slv_ready_o), W'(tab_rdy));
    check("mst_valid", W'(mst_valid_o), W'(m_valid));
    check("busy", W'(busy_o), W'(m_valid));
    if (m_zero) check("reset_data", mst_data_o, '0);
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_empty @%0t: got beat %h expected none", $time, mst_data_o);
      end else begin
        check("mst_data", mst_data_o, exp_q[0]);
        if (r) void'(exp_q.pop_front());
      end
    end

    if (!rn) begin
      model_reset();
    end else begin
`ifdef AR_ARB_STARVE_EN
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!v[i] || exp_rdy[i]) m_cnt[i] = 0;
        else if (m_cnt[i] < MAX_WAIT) m_cnt[i]++;
      end
`endif
      if (exp_load) begin
        if (win >= 0) begin
          beat = slv_data_i[win*ARW +: ARW];
          exp_q.push_back({IDXW'(win), beat});
          m_ptr   = (win + 1) % NUM_REQ;
          m_valid = 1'b1;
          m_zero  = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Round-robin order, stall, single requester, empty-side corners, reset mid-transfer.
    tab.push_back('{1'b1, 4'hF, 1'b1, 4'h1});
    tab.push_back('{1'b1, 4'hF, 1'b1, 4'h2});
    tab.push_back('{1'b1, 4'hF, 1'b1, 4'h4});
    tab.push_back('{1'b1, 4'hF, 1'b1, 4'h8});
    tab.push_back('{1'b1, 4'hF, 1'b1, 4'h1});
    tab.push_back('{1'b1, 4'h4, 1'b1, 4'h4});
    for (int i = 0; i < 5; i++) tab.push_back('{1'b1, 4'hF, 1'b0, 4'h0});
    tab.push_back('{1'b1, 4'hF, 1'b1, 4'h8});
    for (int i = 0; i < 4; i++) tab.push_back('{1'b1, 4'h2, 1'b1, 4'h2});
    tab.push_back('{1'b1, 4'h0, 1'b1, 4'h0});
    tab.push_back('{1'b1, 4'h0, 1'b1, 4'h0});
    tab.push_back('{1'b1, 4'h1, 1'b0, 4'h1});
    tab.push_back('{1'b1, 4'hF, 1'b0, 4'h0});
    tab.push_back('{1'b0, 4'hF, 1'b0, 4'h0});
    tab.push_back('{1'b1, 4'hF, 1'b1, 4'h1});
    tab.push_back('{1'b1, 4'hA, 1'b1, 4'h2});
    tab.push_back('{1'b1, 4'hA, 1'b1, 4'h8});
    tab.push_back('{1'b1, 4'h0, 1'b1, 4'h0});

    rst_ni      = 1'b0;
    slv_valid_i = '0;
    mst_ready_i = 1'b0;
    slv_data_i  = '0;
    @(posedge clk_i);
    #1;
    model_reset();

    repeat (3) cycle(1'b0, 4'hF, 1'b0, 1'b1, 4'h0);

    foreach (tab[i]) begin
`ifdef AR_ARB_STARVE_EN
      cycle(tab[i].rn, tab[i].v, tab[i].r, 1'b0, '0);
`else
      cycle(tab[i].rn, tab[i].v, tab[i].r, 1'b1, tab[i].rdy);
`endif
    end

`ifdef AR_ARB_STARVE_EN
    // Requester 3 waits through a stall, then jumps ahead of pointer candidates 1 and 2.
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
    cycle(1'b1, 4'h1, 1'b0, 1'b1, 4'h1);
    cycle(1'b1, 4'h8, 1'b0, 1'b1, 4'h0);
    cycle(1'b1, 4'h8, 1'b0, 1'b1, 4'h0);
    cycle(1'b1, 4'hE, 1'b1, 1'b1, 4'h8);
    cycle(1'b1, 4'h6, 1'b1, 1'b1, 4'h2);
    cycle(1'b1, 4'h0, 1'b1, 1'b1, 4'h0);
`endif

    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 60) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'b0, '0);
    end
    repeat (3) cycle(1'b1, 4'h0, 1'b1, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
